wam_sch: RTL and testbench
==========================

# wam_sch

Mole scheduler for the Whac-A-Mole game. On each game tick it decides whether a new mole appears and in which of `HOLES` holes, then tracks each mole's lifetime. It also resolves player hits, keeps the two-digit BCD score and counts misses until game over. It consumes the hardness parameters `age`/`rto` from `wam_par` and drives `cout0` back into `wam_hrd`, which closes the difficulty loop.

## Interface
Parameters:
- `HOLES`, 16: number of holes; power of two, 4..16.
- `MISS_MAX`, 8: misses that end the game (1..15).

Ports:
- `clk_19`  in  1  system clock.
- `start`  in  1  reset; synchronous, active-high.
- `tick`  in  1  one-cycle game-step pulse.
- `run`  in  1  level; game enable.
- `age`  in  4  mole lifetime in ticks (0 treated as 1).
- `rto`  in  8  spawn probability per tick, equal to rto/256.
- `hit`  in  HOLES  one-cycle debounced hit pulses, one bit per hole.
- `mol`  out  HOLES  mole present per hole.
- `hit_ok`  out  1  pulse: at least one hit landed on a mole this cycle.
- `whiff`  out  1  pulse: at least one hit landed on an empty hole.
- `miss`  out  1  pulse: at least one mole expired this cycle.
- `scr`  out  8  BCD score, {tens, ones}.
- `cout0`  out  1  pulse when the ones digit wraps 9→0.
- `mcnt`  out  4  miss count.
- `over`  out  1  high in state OVER.

## Operation
- State machine:
  - IDLE → PLAY when `run`=1.
  - PLAY → OVER in the cycle `mcnt` reaches `MISS_MAX`.
  - PLAY → IDLE when `run`=0; moles are cleared, score is kept.
  - OVER → IDLE when `run`=0.
  - `start` forces IDLE from any state.
- LFSR: 16-bit Galois, mask 16'hB400, seed 16'hACE1 on `start`. It advances every cycle, not only on tick, so that player timing adds entropy.
- Spawn, evaluated only in PLAY on `tick`:
  - Candidate hole `idx` = lfsr[log2(HOLES)-1:0].
  - Spawn happens if lfsr[15:8] < `rto` and `mol[idx]`=0 at the start of the cycle. Otherwise nothing happens: no retry, no alternate hole.
  - On spawn, the hole's lifetime counter loads max(`age`,1).
- Lifetime, per hole, only on `tick` in PLAY:
  - If the counter is 1, the mole expires: `mol` bit clears and the hole contributes to `miss`.
  - Otherwise the counter decrements.
  - A hole that spawns on this tick does not also decrement.
- Hits, in PLAY every cycle:
  - Each `hit[i]` with `mol[i]`=1 clears that hole.
  - If any such hit occurs, `hit_ok` pulses and the score increments by exactly 1 per cycle, however many holes were hit.
  - Any `hit[i]` with `mol[i]`=0 pulses `whiff`.
  - In IDLE and OVER, hits are ignored and no pulses are produced.
- Score:
  - The ones digit wraps 9→0 with a tens increment and a `cout0` pulse.
  - The score saturates at 8'h99; once there, further hits produce `hit_ok` but no `cout0`.
- Misses:
  - `mcnt` increments by 1 per cycle in which any mole expires.
  - `mcnt` saturates at `MISS_MAX`.
- Entering OVER clears all `mol` bits.

## Timing
- All outputs are registered.
- Reset values: `mol`=0, `hit_ok`=`whiff`=`miss`=`cout0`=0, `scr`=8'h00, `mcnt`=0, `over`=0, state IDLE, LFSR=16'hACE1.
- Every pulse output is high for exactly one cycle, in the cycle after its cause is sampled.
- The `mol` bit updates one cycle after the spawn, hit or expiry that causes it.
- Same hole, same cycle:
  - Hit and expiry together: the hit wins. `hit_ok` pulses, `miss` does not, and `mcnt` is unchanged.
  - Hit on an empty hole on the tick that spawns into it: counts as a whiff, and the spawn proceeds.
- `age`/`rto` are sampled at spawn time only; a hardness change does not alter live counters.
- `start` in mid-game clears everything on the next edge, pending pulses included.
- `over` rises in the same cycle that `mcnt` reaches `MISS_MAX`, with `mol`=0 in that cycle.

## Test plan
- **Reset.** Assert `start`, then release with `run`=0 and 20 ticks → all outputs at reset values; `mol` stays 0.
- **Spawn and expiry.** `run`=1, `rto`=8'hFF, `age`=3, force an LFSR state giving idx 5 → `mol[5]` sets; `miss` pulses on the 3rd following tick; `mcnt`=1.
- **Hit and score.** Pulse `hit[5]` while `mol[5]`=1 → `hit_ok` pulse, `scr`=8'h01. Drive 9 more landed hits → `scr`=8'h10 with one `cout0` pulse.
- **Simultaneous events.** `hit[i]` in the same cycle as the expiring tick → `hit_ok`=1, `miss`=0, `mcnt` unchanged. Hit on an empty hole → `whiff` only.
- **Game over.** `MISS_MAX`=2, let 2 moles expire → `over`=1 and `mol`=0; further ticks and hits cause no change. Drop `run` → IDLE.
- **Saturation and spawn block.** Preload `scr` to 99 and hit → `scr` stays 8'h99, no `cout0`. With `rto`=0 → no spawns over 100 ticks. Spawn targeting an occupied hole → no change.

Source files
------------

// File: rtl/wam_sch.sv
// Mole scheduler: spawns moles from an LFSR, ages them per tick, resolves hits, keeps BCD score and miss count.
// Latency: every output is registered; effects of a sampled spawn/hit/expiry appear one cycle later.
// Backpressure: none; tick and hit are single-cycle pulses that are consumed in the cycle they are sampled.
module wam_sch #(
  parameter int HOLES    = 16,
  parameter int MISS_MAX = 8
) (
  input  logic             clk_19,
  input  logic             start,
  input  logic             tick,
  input  logic             run,
  input  logic [3:0]       age,
  input  logic [7:0]       rto,
  input  logic [HOLES-1:0] hit,
  output logic [HOLES-1:0] mol,
  output logic             hit_ok,
  output logic             whiff,
  output logic             miss,
  output logic [7:0]       scr,
  output logic             cout0,
  output logic [3:0]       mcnt,
  output logic             over
);

  localparam int         IW   = $clog2(HOLES);
  localparam logic [3:0] MMAX = 4'(MISS_MAX);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t           state, state_n;
  logic [15:0]      lfsr, lfsr_n;
  logic [HOLES-1:0] mol_n;
  logic [3:0]       cnt   [HOLES];
  logic [3:0]       cnt_n [HOLES];
  logic             hit_ok_n, whiff_n, miss_n, cout0_n;
  logic [7:0]       scr_n;
  logic [3:0]       mcnt_n;

  logic [IW-1:0]    idx;
  logic [3:0]       age_eff;
  logic [HOLES-1:0] land, empty, expire, spawn;

  assign idx     = lfsr[IW-1:0];
  assign age_eff = (age == 4'd0) ? 4'd1 : age;
  assign over    = (state == OVER);

  // Galois LFSR step, free-running so that player timing perturbs which value a tick sees
  always_comb begin
    lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  end

  // Per-hole events; a hit on an expiring hole takes precedence over the expiry
  always_comb begin
    land   = hit & mol;
    empty  = hit & ~mol;
    expire = '0;
    spawn  = '0;
    for (int i = 0; i < HOLES; i++) begin
      expire[i] = tick && mol[i] && (cnt[i] == 4'd1) && !hit[i];
    end
    if (tick && (lfsr[15:8] < rto) && !mol[idx]) begin
      spawn[idx] = 1'b1;
    end
  end

  // Next-state and next-output logic; only PLAY produces events
  always_comb begin
    state_n  = state;
    mol_n    = mol;
    cnt_n    = cnt;
    hit_ok_n = 1'b0;
    whiff_n  = 1'b0;
    miss_n   = 1'b0;
    cout0_n  = 1'b0;
    scr_n    = scr;
    mcnt_n   = mcnt;
    case (state)
      IDLE: begin
        if (run) state_n = PLAY;
      end
      PLAY: begin
        if (!run) begin
          state_n = IDLE;
          mol_n   = '0;
        end else begin
          mol_n = (mol & ~land & ~expire) | spawn;
          for (int i = 0; i < HOLES; i++) begin
            if (spawn[i]) begin
              cnt_n[i] = age_eff;
            end else if (tick && mol[i] && (cnt[i] != 4'd1)) begin
              cnt_n[i] = cnt[i] - 4'd1;
            end
          end
          hit_ok_n = |land;
          whiff_n  = |empty;
          miss_n   = |expire;
          // One point per cycle regardless of how many moles were hit; score sticks at 99
          if ((|land) && (scr != 8'h99)) begin
            if (scr[3:0] == 4'd9) begin
              scr_n   = {scr[7:4] + 4'd1, 4'd0};
              cout0_n = 1'b1;
            end else begin
              scr_n = scr + 8'd1;
            end
          end
          if ((|expire) && (mcnt != MMAX)) mcnt_n = mcnt + 4'd1;
          if ((|expire) && (mcnt_n == MMAX)) begin
            state_n = OVER;
            mol_n   = '0;
          end
        end
      end
      OVER: begin
        if (!run) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_19) begin
    if (start) state <= IDLE;
    else       state <= state_n;
  end

  // Datapath registers; start also drops any pulse that would have fired this edge
  always_ff @(posedge clk_19) begin
    if (start) begin
      lfsr   <= 16'hACE1;
      mol    <= '0;
      hit_ok <= 1'b0;
      whiff  <= 1'b0;
      miss   <= 1'b0;
      cout0  <= 1'b0;
      scr    <= 8'h00;
      mcnt   <= 4'd0;
      for (int i = 0; i < HOLES; i++) cnt[i] <= 4'd0;
    end else begin
      lfsr   <= lfsr_n;
      mol    <= mol_n;
      hit_ok <= hit_ok_n;
      whiff  <= whiff_n;
      miss   <= miss_n;
      cout0  <= cout0_n;
      scr    <= scr_n;
      mcnt   <= mcnt_n;
      for (int i = 0; i < HOLES; i++) cnt[i] <= cnt_n[i];
    end
  end

endmodule

// File: tb/tb_wam_sch.sv
// Directed bench for wam_sch (HOLES=16, MISS_MAX=2).
// Tracks the spawn LFSR locally to choose when a tick lands on a wanted hole.
// Inputs driven and outputs sampled on the falling edge.
module tb_wam_sch;
  logic        clk_19 = 1'b0;
  logic        start, tick, run;
  logic [3:0]  age;
  logic [7:0]  rto;
  logic [15:0] hit;
  logic [15:0] mol;
  logic        hit_ok, whiff, miss, cout0, over;
  logic [7:0]  scr;
  logic [3:0]  mcnt;

  wam_sch #(.HOLES(16), .MISS_MAX(2)) dut (
    .clk_19(clk_19), .start(start), .tick(tick), .run(run), .age(age), .rto(rto),
    .hit(hit), .mol(mol), .hit_ok(hit_ok), .whiff(whiff), .miss(miss),
    .scr(scr), .cout0(cout0), .mcnt(mcnt), .over(over)
  );

  always #5 clk_19 = ~clk_19;

  int total  = 0;
  int passed = 0;

  // Predicted LFSR value, seeded whenever start is sampled
  logic [15:0] pl;
  always @(posedge clk_19) pl <= start ? 16'hACE1 : (pl[0] ? ((pl >> 1) ^ 16'hB400) : (pl >> 1));

  typedef struct packed {
    logic       sp;  // spawn a fresh mole first
    logic       mh;  // hit the mole
    logic       eh;  // hit an empty neighbouring hole
    logic       ok;
    logic       wf;
    logic [7:0] sc;
    logic       co;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input logic t, input logic [15:0] h);
    tick = t;
    hit  = h;
    @(posedge clk_19);
    @(negedge clk_19);
    tick = 1'b0;
    hit  = '0;
  endtask

  // Idle until the predicted LFSR makes a spawn candidate: a given hole, or any hole not in excl
  task automatic wait_for(input int want, input logic [15:0] excl, output int h);
    logic found;
    int   n;
    found = 1'b0;
    n     = 0;
    h     = 0;
    while (!found && n < 4000) begin
      if ((pl[15:8] < rto) && ((want < 0) ? !excl[pl[3:0]] : (int'(pl[3:0]) == want))) begin
        found = 1'b1;
        h     = int'(pl[3:0]);
      end else begin
        cyc(1'b0, '0);
        n++;
      end
    end
    if (!found) begin
      total++;
      $display("FAIL wait_for: no spawn slot for hole %0d within %0d cycles", want, n);
    end
  endtask

  function automatic logic [7:0] bcd(input int s);
    return 8'(((s / 10) << 4) | (s % 10));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          h, a, b, s;
    logic        seen;
    logic [15:0] hm;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h04, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h06, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h07, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h08, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h09, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11, 1'b0};

    // Reset, then 20 ticks while not running
    start = 1'b1; run = 1'b0; tick = 1'b0; hit = '0; age = 4'd3; rto = 8'hFF;
    repeat (2) @(posedge clk_19);
    @(negedge clk_19);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, '0);
      if (mol != 16'h0) seen = 1'b1;
    end
    chk("idle_mol_stays_0", seen, 0);
    chk("rst_mol", mol, 0);
    chk("rst_hit_ok", hit_ok, 0);
    chk("rst_whiff", whiff, 0);
    chk("rst_miss", miss, 0);
    chk("rst_scr", scr, 8'h00);
    chk("rst_cout0", cout0, 0);
    chk("rst_mcnt", mcnt, 0);
    chk("rst_over", over, 0);

    // Spawn into hole 5 with age 3, let it expire
    run = 1'b1;
    cyc(1'b0, '0);
    wait_for(5, 16'h0, h);
    cyc(1'b1, '0);
    rto = 8'h00;
    chk("spawn5_mol", mol, 16'h0020);
    cyc(1'b1, '0);
    chk("age_t1_miss", miss, 0);
    cyc(1'b1, '0);
    chk("age_t2_miss", miss, 0);
    chk("age_t2_mol", mol, 16'h0020);
    cyc(1'b1, '0);
    chk("expire_miss", miss, 1);
    chk("expire_mol", mol, 16'h0);
    chk("expire_mcnt", mcnt, 1);
    chk("expire_over", over, 0);
    cyc(1'b0, '0);
    chk("miss_one_cycle", miss, 0);

    // Hit/score table, age long enough that nothing expires
    age = 4'd15;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].sp) begin
        rto = 8'hFF;
        wait_for(-1, 16'h0, h);
        cyc(1'b1, '0);
        rto = 8'h00;
        chk("tbl_spawn_mol", mol, 16'd1 << h);
      end
      hm = (tbl[i].mh ? (16'd1 << h) : 16'h0) | (tbl[i].eh ? (16'd1 << ((h + 1) % 16)) : 16'h0);
      cyc(1'b0, hm);
      chk("tbl_hit_ok", hit_ok, tbl[i].ok);
      chk("tbl_whiff", whiff, tbl[i].wf);
      chk("tbl_scr", scr, tbl[i].sc);
      chk("tbl_cout0", cout0, tbl[i].co);
    end

    // Two moles hit in one cycle score a single point
    rto = 8'hFF;
    wait_for(-1, 16'h0, a);
    cyc(1'b1, '0);
    wait_for(-1, 16'd1 << a, b);
    cyc(1'b1, '0);
    rto = 8'h00;
    chk("two_moles", mol, (16'd1 << a) | (16'd1 << b));
    cyc(1'b0, (16'd1 << a) | (16'd1 << b));
    chk("multi_hit_ok", hit_ok, 1);
    chk("multi_hit_scr", scr, 8'h12);
    chk("multi_hit_mol", mol, 16'h0);

    // Hit on the expiring tick: hit wins
    age = 4'd0;
    rto = 8'hFF;
    wait_for(-1, 16'h0, h);
    cyc(1'b1, '0);
    rto = 8'h00;
    cyc(1'b1, 16'd1 << h);
    chk("race_hit_ok", hit_ok, 1);
    chk("race_miss", miss, 0);
    chk("race_mcnt", mcnt, 1);
    chk("race_mol", mol, 16'h0);
    chk("race_scr", scr, 8'h13);

    // Hit on the hole a tick spawns into: whiff, spawn proceeds
    age = 4'd15;
    rto = 8'hFF;
    wait_for(-1, 16'h0, h);
    cyc(1'b1, 16'd1 << h);
    chk("spawnhit_whiff", whiff, 1);
    chk("spawnhit_ok", hit_ok, 0);
    chk("spawnhit_mol", mol, 16'd1 << h);
    // Spawn aimed at the occupied hole is dropped
    wait_for(h, 16'h0, a);
    cyc(1'b1, '0);
    chk("occupied_block", mol, 16'd1 << h);
    rto = 8'h00;
    cyc(1'b0, 16'd1 << h);
    chk("occ_clear_scr", scr, 8'h14);

    // rto=0: no spawns over 100 ticks
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, '0);
      if (mol != 16'h0) seen = 1'b1;
    end
    chk("rto0_no_spawn", seen, 0);

    // Drive score to 99, then check saturation
    s = 14;
    while (s < 99) begin
      rto = 8'hFF;
      wait_for(-1, 16'h0, h);
      cyc(1'b1, '0);
      rto = 8'h00;
      cyc(1'b0, 16'd1 << h);
      s++;
    end
    chk("preload_scr", scr, bcd(99));
    rto = 8'hFF;
    wait_for(-1, 16'h0, h);
    cyc(1'b1, '0);
    rto = 8'h00;
    cyc(1'b0, 16'd1 << h);
    chk("sat_hit_ok", hit_ok, 1);
    chk("sat_scr", scr, 8'h99);
    chk("sat_cout0", cout0, 0);
    chk("pre_over_mcnt", mcnt, 1);

    // Second expiry ends the game while another mole is alive
    rto = 8'hFF;
    wait_for(-1, 16'h0, a);
    cyc(1'b1, '0);
    age = 4'd0;
    wait_for(-1, 16'd1 << a, b);
    cyc(1'b1, '0);
    rto = 8'h00;
    cyc(1'b1, '0);
    chk("over_miss", miss, 1);
    chk("over_mcnt", mcnt, 2);
    chk("over_flag", over, 1);
    chk("over_mol", mol, 16'h0);
    rto = 8'hFF;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 16'hFFFF);
      if (mol != 16'h0 || hit_ok || whiff || miss || cout0 || scr != 8'h99 || mcnt != 4'd2 || !over)
        seen = 1'b1;
    end
    chk("over_frozen", seen, 0);
    run = 1'b0;
    cyc(1'b0, '0);
    chk("over_to_idle", over, 0);
    chk("idle_keeps_scr", scr, 8'h99);

    // start mid-game clears everything, including a pending hit pulse
    run = 1'b1;
    age = 4'd15;
    cyc(1'b0, '0);
    wait_for(-1, 16'h0, h);
    cyc(1'b1, '0);
    chk("restart_spawn", mol, 16'd1 << h);
    start = 1'b1;
    cyc(1'b0, 16'd1 << h);
    start = 1'b0;
    chk("start_mol", mol, 16'h0);
    chk("start_hit_ok", hit_ok, 0);
    chk("start_scr", scr, 8'h00);
    chk("start_mcnt", mcnt, 0);
    chk("start_over", over, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
